// File: rtl/gpr_writeback_pkg.sv
// ---------------------------------------------------------------------------
// gpr_writeback_pkg
//   Shared definitions for the GPR write-back slice: load-type encodings as
//   they arrive from the MEM stage, the hard-wired zero register index, and
//   the write-port source selector used by the write-back arbiter.
// ---------------------------------------------------------------------------
package gpr_writeback_pkg;

    // Load-type encodings on pipe_ld_type. Codes 5-7 behave like LD_W.
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    // Register 0 is hard-wired to zero and must never be written.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // What drives the GPR write port on the next edge.
    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,   // nothing to write, hold address/data
        WB_PIPE     = 2'd1,   // MEM/WB pipeline write
        WB_POP_LIVE = 2'd2,   // drain a live MDU result from the buffer
        WB_POP_DEAD = 2'd3    // drain an invalidated MDU result silently
    } wb_src_e;

endpackage

// File: rtl/gpr_writeback_pend_fifo.sv
// ---------------------------------------------------------------------------
// wb_pend_fifo
//   Circular buffer holding MDU results waiting for an idle GPR write slot.
//   Each slot carries an occupancy bit and a separate live bit: a younger
//   pipeline write to the same register clears the live bit but the slot
//   stays occupied until it reaches the head and is popped.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   push                store push_a3/push_wd at the write pointer
//   pop                 retire the head entry (caller guarantees non-empty)
//   inval, inval_a3     clear the live bit of every occupied slot with a3 match
//   qa1, qa2            decode source registers to compare against live slots
//   q_hit1, q_hit2      qaN non-zero and matches a live slot
//   head_live           head slot is still live (write it) vs stale (drop it)
//   head_a3, head_wd    head slot contents
//   count               number of occupied slots
// ---------------------------------------------------------------------------
module wb_pend_fifo
    import gpr_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [4:0]               push_a3,
    input  logic [31:0]              push_wd,
    input  logic                     pop,
    input  logic                     inval,
    input  logic [4:0]               inval_a3,
    input  logic [4:0]               qa1,
    input  logic [4:0]               qa2,
    output logic                     q_hit1,
    output logic                     q_hit2,
    output logic                     head_live,
    output logic [4:0]               head_a3,
    output logic [31:0]              head_wd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]       slot_a3 [DEPTH];
    logic [31:0]      slot_wd [DEPTH];
    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] live;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Control state. Invalidation is applied before the push so that an entry
    // entering the buffer on this edge is never killed by a write that was
    // already in the pipeline alongside it; only entries already pending are
    // considered older than the pipeline write. DEPTH is a power of two, so
    // the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ    <= '0;
            live   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (inval && occ[i] && (slot_a3[i] == inval_a3)) begin
                    live[i] <= 1'b0;
                end
            end
            if (pop) begin
                occ[rd_ptr]  <= 1'b0;
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PW'(1);
            end
            if (push) begin
                occ[wr_ptr]  <= 1'b1;
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset: a slot is only read once occ marks it.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_a3[wr_ptr] <= push_a3;
            slot_wd[wr_ptr] <= push_wd;
        end
    end

    assign head_live = live[rd_ptr];
    assign head_a3   = slot_a3[rd_ptr];
    assign head_wd   = slot_wd[rd_ptr];

    // Hazard lookup for decode. Stale slots will never write the register,
    // so they must not stall anything.
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && live[i] && (qa1 != REG_ZERO) && (slot_a3[i] == qa1)) begin
                q_hit1 = 1'b1;
            end
            if (occ[i] && live[i] && (qa2 != REG_ZERO) && (slot_a3[i] == qa2)) begin
                q_hit2 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_writeback.sv
// ---------------------------------------------------------------------------
// gpr_writeback
//   GPR write-port driver: MEM/WB stage register with load-data extraction
//   and sign/zero extension, merged with results from the multi-cycle
//   mult/div unit through a small pending buffer. Pipeline writes win the
//   port; buffered MDU results drain into otherwise idle cycles. The write
//   port is driven from registers, one write per cycle.
//
// Ports
//   clk, reset                    clock; synchronous active-high reset
//   pipe_valid/we/a3/wd           MEM-stage instruction and its result
//   pipe_ld_type, pipe_addr_lo    load kind and byte offset for extraction
//   mdu_valid/a3/wd, mdu_ready    MDU result handshake into the buffer
//   qa1, qa2 -> q_hit1, q_hit2    decode sources pending in the buffer
//   gpr_we, gpr_a3, gpr_wd        registered GPR write port
//   pend_count                    occupied buffer slots (including stale)
// ---------------------------------------------------------------------------
module gpr_writeback
    import gpr_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_valid,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_a3,
    input  logic [31:0]              pipe_wd,
    input  logic [2:0]               pipe_ld_type,
    input  logic [1:0]               pipe_addr_lo,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_a3,
    input  logic [31:0]              mdu_wd,
    input  logic [4:0]               qa1,
    input  logic [4:0]               qa2,
    output logic                     q_hit1,
    output logic                     q_hit2,
    output logic                     gpr_we,
    output logic [4:0]               gpr_a3,
    output logic [31:0]              gpr_wd,
    output logic [$clog2(DEPTH):0]   pend_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic        pipe_slot;
    logic        mdu_push;
    logic        buf_pop;
    logic        head_live;
    logic [4:0]  head_a3;
    logic [31:0] head_wd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    wb_src_e     wb_src;

    // A pipeline instruction targeting r0 is treated as a non-writer.
    assign pipe_slot = pipe_valid && pipe_we && (pipe_a3 != REG_ZERO);

    // Ready looks only at the registered count: a pop on this edge does not
    // free a slot for a push on the same edge.
    assign mdu_ready = (pend_count < CW'(DEPTH));

    // MDU results for r0 complete the handshake but are dropped here.
    assign mdu_push = mdu_valid && mdu_ready && (mdu_a3 != REG_ZERO);

    assign buf_pop = !pipe_slot && (pend_count != '0);

    // Little-endian lane selection; for halfwords only addr_lo[1] matters.
    always_comb begin
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        ld_data = pipe_wd;
        case (pipe_addr_lo)
            2'd0:    ld_byte = pipe_wd[7:0];
            2'd1:    ld_byte = pipe_wd[15:8];
            2'd2:    ld_byte = pipe_wd[23:16];
            default: ld_byte = pipe_wd[31:24];
        endcase
        ld_half = pipe_addr_lo[1] ? pipe_wd[31:16] : pipe_wd[15:0];
        case (pipe_ld_type)
            LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   ld_data = {24'h000000, ld_byte};
            LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LD_HU:   ld_data = {16'h0000, ld_half};
            default: ld_data = pipe_wd;
        endcase
    end

    // Write-port arbitration for the coming edge.
    always_comb begin
        wb_src = WB_IDLE;
        if (pipe_slot) begin
            wb_src = WB_PIPE;
        end else if (pend_count != '0) begin
            wb_src = head_live ? WB_POP_LIVE : WB_POP_DEAD;
        end
    end

    // Registered write port. Address and data hold when no write issues so
    // the port does not toggle on idle or stale-drop cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpr_we <= 1'b0;
            gpr_a3 <= REG_ZERO;
            gpr_wd <= 32'h0000_0000;
        end else begin
            case (wb_src)
                WB_PIPE: begin
                    gpr_we <= 1'b1;
                    gpr_a3 <= pipe_a3;
                    gpr_wd <= ld_data;
                end
                WB_POP_LIVE: begin
                    gpr_we <= 1'b1;
                    gpr_a3 <= head_a3;
                    gpr_wd <= head_wd;
                end
                default: begin
                    gpr_we <= 1'b0;
                end
            endcase
        end
    end

    // A pipeline write makes any older pending result for the same register
    // obsolete; the buffer keeps the slot but stops treating it as live.
    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_pend (
        .clk       (clk),
        .reset     (reset),
        .push      (mdu_push),
        .push_a3   (mdu_a3),
        .push_wd   (mdu_wd),
        .pop       (buf_pop),
        .inval     (pipe_slot),
        .inval_a3  (pipe_a3),
        .qa1       (qa1),
        .qa2       (qa2),
        .q_hit1    (q_hit1),
        .q_hit2    (q_hit2),
        .head_live (head_live),
        .head_a3   (head_a3),
        .head_wd   (head_wd),
        .count     (pend_count)
    );

endmodule

// File: tb/tb_gpr_writeback.sv
// ---------------------------------------------------------------------------
// tb_gpr_writeback
//   Directed scenarios followed by randomized traffic for gpr_writeback.
//   A queue-based reference model predicts the write port, buffer occupancy,
//   ready and hazard outputs every cycle.
// ---------------------------------------------------------------------------
module tb_gpr_writeback;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        pipe_valid;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [2:0]  pipe_ld_type;
    logic [1:0]  pipe_addr_lo;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_a3;
    logic [31:0] mdu_wd;
    logic [4:0]  qa1;
    logic [4:0]  qa2;
    logic        q_hit1;
    logic        q_hit2;
    logic        gpr_we;
    logic [4:0]  gpr_a3;
    logic [31:0] gpr_wd;
    logic [$clog2(DEPTH):0] pend_count;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        bit          live;
    } entry_t;

    entry_t      mq[$];
    logic        expWe;
    logic [4:0]  expA3;
    logic [31:0] expWd;

    gpr_writeback #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_valid   (pipe_valid),
        .pipe_we      (pipe_we),
        .pipe_a3      (pipe_a3),
        .pipe_wd      (pipe_wd),
        .pipe_ld_type (pipe_ld_type),
        .pipe_addr_lo (pipe_addr_lo),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_a3       (mdu_a3),
        .mdu_wd       (mdu_wd),
        .qa1          (qa1),
        .qa2          (qa2),
        .q_hit1       (q_hit1),
        .q_hit2       (q_hit2),
        .gpr_we       (gpr_we),
        .gpr_a3       (gpr_a3),
        .gpr_wd       (gpr_wd),
        .pend_count   (pend_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Load result computed from the lane arithmetic of a little-endian word.
    function automatic logic [31:0] modelLoad(input logic [2:0] t, input logic [31:0] w,
                                              input logic [1:0] lo);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'h0000_00FF;
        h = (w >> (16 * (lo / 2))) & 32'h0000_FFFF;
        case (t)
            3'd1:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic modelHit(input logic [4:0] qa);
        if (qa == 5'd0) return 1'b0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].a3 == qa) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic modelStep();
        bit     slot;
        bit     acc;
        entry_t e;
        if (reset) begin
            mq.delete();
            expWe = 1'b0;
            expA3 = 5'd0;
            expWd = 32'd0;
            return;
        end
        slot = pipe_valid && pipe_we && (pipe_a3 != 5'd0);
        acc  = mdu_valid && (mq.size() < DEPTH) && (mdu_a3 != 5'd0);
        if (slot) begin
            foreach (mq[i]) begin
                if (mq[i].a3 == pipe_a3) mq[i].live = 1'b0;
            end
            expWe = 1'b1;
            expA3 = pipe_a3;
            expWd = modelLoad(pipe_ld_type, pipe_wd, pipe_addr_lo);
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            expWe = e.live;
            if (e.live) begin
                expA3 = e.a3;
                expWd = e.wd;
            end
        end else begin
            expWe = 1'b0;
        end
        if (acc) begin
            e.a3   = mdu_a3;
            e.wd   = mdu_wd;
            e.live = 1'b1;
            mq.push_back(e);
        end
    endtask

    task automatic setIdle();
        reset        = 1'b0;
        pipe_valid   = 1'b0;
        pipe_we      = 1'b0;
        pipe_a3      = 5'd0;
        pipe_wd      = 32'd0;
        pipe_ld_type = 3'd0;
        pipe_addr_lo = 2'd0;
        mdu_valid    = 1'b0;
        mdu_a3       = 5'd0;
        mdu_wd       = 32'd0;
        qa1          = 5'd0;
        qa2          = 5'd0;
    endtask

    task automatic setPipe(input logic [4:0] a3, input logic [31:0] wd,
                           input logic [2:0] lt, input logic [1:0] lo);
        pipe_valid   = 1'b1;
        pipe_we      = 1'b1;
        pipe_a3      = a3;
        pipe_wd      = wd;
        pipe_ld_type = lt;
        pipe_addr_lo = lo;
    endtask

    task automatic setMdu(input logic [4:0] a3, input logic [31:0] wd);
        mdu_valid = 1'b1;
        mdu_a3    = a3;
        mdu_wd    = wd;
    endtask

    // One cycle: combinational checks with the new inputs settled, model
    // update, then registered-output checks just after the clock edge.
    task automatic applyStimulus();
        #1;
        checkOutput("pend_count", 32'(pend_count), 32'(mq.size()));
        checkOutput("mdu_ready",  32'(mdu_ready),  32'(mq.size() < DEPTH));
        checkOutput("q_hit1",     32'(q_hit1),     32'(modelHit(qa1)));
        checkOutput("q_hit2",     32'(q_hit2),     32'(modelHit(qa2)));
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("gpr_we", 32'(gpr_we), 32'(expWe));
        checkOutput("gpr_a3", 32'(gpr_a3), 32'(expA3));
        checkOutput("gpr_wd", gpr_wd, expWd);
        checkOutput("no_r0_write", 32'(gpr_we && (gpr_a3 == 5'd0)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        setIdle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        expWe = 1'b0;
        expA3 = 5'd0;
        expWd = 32'd0;

        // Reset state
        setIdle(); reset = 1'b1; setPipe(5'd7, 32'h1111_2222, 3'd0, 2'd0); applyStimulus();
        checkOutput("reset_we", 32'(gpr_we), 32'd0);
        setIdle(); applyStimulus();
        checkOutput("reset_ready", 32'(mdu_ready), 32'd1);

        // Load extraction
        setIdle(); setPipe(5'd5, 32'h80FF_1234, 3'd1, 2'd3); applyStimulus();
        checkOutput("lb_wd", gpr_wd, 32'hFFFF_FF80);
        checkOutput("lb_a3", 32'(gpr_a3), 32'd5);
        setIdle(); setPipe(5'd5, 32'h80FF_1234, 3'd2, 2'd3); applyStimulus();
        checkOutput("lbu_wd", gpr_wd, 32'h0000_0080);
        setIdle(); setPipe(5'd6, 32'h8001_7FFF, 3'd3, 2'd2); applyStimulus();
        checkOutput("lh2_wd", gpr_wd, 32'hFFFF_8001);
        setIdle(); setPipe(5'd6, 32'h8001_7FFF, 3'd3, 2'd3); applyStimulus();
        checkOutput("lh3_wd", gpr_wd, 32'hFFFF_8001);
        setIdle(); setPipe(5'd6, 32'h8001_7FFF, 3'd4, 2'd2); applyStimulus();
        checkOutput("lhu_wd", gpr_wd, 32'h0000_8001);
        setIdle(); setPipe(5'd6, 32'h8001_7FFF, 3'd3, 2'd0); applyStimulus();
        checkOutput("lh0_wd", gpr_wd, 32'h0000_7FFF);
        setIdle(); setPipe(5'd6, 32'h8001_7FFF, 3'd6, 2'd1); applyStimulus();
        checkOutput("ld6_wd", gpr_wd, 32'h8001_7FFF);

        // MDU result held behind three pipeline writes
        setIdle(); setPipe(5'd3, 32'h0000_0001, 3'd0, 2'd0); setMdu(5'd8, 32'h0000_1234);
        qa1 = 5'd8; applyStimulus();
        for (int i = 0; i < 2; i++) begin
            setIdle(); setPipe(5'd3, 32'(i), 3'd0, 2'd0); qa1 = 5'd8; applyStimulus();
            checkOutput("held_count", 32'(pend_count), 32'd1);
        end
        setIdle(); qa1 = 5'd8; #1;
        checkOutput("held_hit1", 32'(q_hit1), 32'd1);
        applyStimulus();
        checkOutput("drain_we", 32'(gpr_we), 32'd1);
        checkOutput("drain_a3", 32'(gpr_a3), 32'd8);
        checkOutput("drain_wd", gpr_wd, 32'h0000_1234);
        checkOutput("drain_count", 32'(pend_count), 32'd0);

        // Fill the buffer, third result must wait for a pop
        setIdle(); setPipe(5'd3, 32'h1, 3'd0, 2'd0); setMdu(5'd10, 32'hA0); applyStimulus();
        setIdle(); setPipe(5'd3, 32'h2, 3'd0, 2'd0); setMdu(5'd11, 32'hB0); applyStimulus();
        setIdle(); setPipe(5'd3, 32'h3, 3'd0, 2'd0); setMdu(5'd12, 32'hC0); #1;
        checkOutput("full_ready", 32'(mdu_ready), 32'd0);
        applyStimulus();
        checkOutput("full_count", 32'(pend_count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            setIdle(); setMdu(5'd12, 32'hC0);
            if (i >= 2) mdu_valid = 1'b0;
            applyStimulus();
        end

        // WAW: pipeline write supersedes a pending result
        setIdle(); setPipe(5'd3, 32'h4, 3'd0, 2'd0); setMdu(5'd9, 32'h5555); applyStimulus();
        setIdle(); setPipe(5'd9, 32'hAAAA, 3'd0, 2'd0); qa2 = 5'd9; applyStimulus();
        checkOutput("waw_wd", gpr_wd, 32'h0000_AAAA);
        setIdle(); qa2 = 5'd9; #1;
        checkOutput("waw_hit2", 32'(q_hit2), 32'd0);
        applyStimulus();
        checkOutput("stale_we", 32'(gpr_we), 32'd0);
        checkOutput("stale_wd", gpr_wd, 32'h0000_AAAA);

        // Writes to r0 from either source
        setIdle(); setPipe(5'd0, 32'hDEAD, 3'd0, 2'd0); setMdu(5'd0, 32'hBEEF); applyStimulus();
        checkOutput("r0_we", 32'(gpr_we), 32'd0);
        setIdle(); applyStimulus();
        checkOutput("r0_count", 32'(pend_count), 32'd0);

        // Reset with two pending entries
        setIdle(); setPipe(5'd3, 32'h5, 3'd0, 2'd0); setMdu(5'd13, 32'hD0); applyStimulus();
        setIdle(); setPipe(5'd3, 32'h6, 3'd0, 2'd0); setMdu(5'd14, 32'hE0); applyStimulus();
        setIdle(); reset = 1'b1; applyStimulus();
        for (int i = 0; i < 3; i++) begin
            setIdle(); applyStimulus();
            checkOutput("post_reset_we", 32'(gpr_we), 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            setIdle();
            reset        = ($urandom_range(0, 99) == 0);
            pipe_valid   = ($urandom_range(0, 1) == 1);
            pipe_we      = ($urandom_range(0, 3) != 0);
            pipe_a3      = 5'($urandom_range(0, 7));
            pipe_wd      = $urandom;
            pipe_ld_type = 3'($urandom_range(0, 7));
            pipe_addr_lo = 2'($urandom_range(0, 3));
            mdu_valid    = ($urandom_range(0, 1) == 1);
            mdu_a3       = 5'($urandom_range(0, 7));
            mdu_wd       = $urandom;
            qa1          = 5'($urandom_range(0, 7));
            qa2          = 5'($urandom_range(0, 7));
            if (pipe_valid && pipe_we && pipe_a3 != 5'd0 && mdu_valid && mdu_a3 == pipe_a3) begin
                mdu_a3 = pipe_a3 ^ 5'd1;
            end
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
